// File: rtl/gen_chiplet_fdi_hs_seq.sv
// Sequences NUM_CH four-phase req/ack handshakes: ascending bring-up, descending release,
// with per-channel enables, per-stage timeout, abort on stop and error capture.
module gen_chiplet_fdi_hs_seq #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              swrst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] req_o,
  output logic              done_o,
  output logic              stopped_o,
  output logic              active_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [CH_W-1:0]   err_ch_o,
  output logic              err_dir_o
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]  IDX_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_UP, S_ACTIVE, S_DOWN, S_ERR} state_t;

  state_t             state_q;
  logic [NUM_CH-1:0]  req_q, en_q;
  logic [CH_W-1:0]    idx_q, err_ch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q, stopped_q, active_q, busy_q, err_q, err_dir_q;

  logic [CNT_W-1:0]   cnt_d;
  logic [CH_W-1:0]    idx_inc_d, idx_dec_d, drop_idx_d;
  logic [NUM_CH-1:0]  drop_d;
  logic               cur_en_d, cur_ack_d, to_hit_d;

  assign cur_en_d  = en_q[idx_q];
  assign cur_ack_d = ack_i[idx_q];
  assign idx_inc_d = idx_q + CH_W'(1);
  assign idx_dec_d = idx_q - CH_W'(1);
  // Saturating count: with the timeout disabled it parks at all-ones instead of wrapping.
  assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign to_hit_d  = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
  assign drop_d    = en_q & req_q & ~ack_i;

  always_comb begin
    drop_idx_d = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (drop_d[i-1]) drop_idx_d = CH_W'(i - 1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE; req_q <= '0; en_q <= '0; idx_q <= '0; cnt_q <= '0;
      done_q <= 1'b0; stopped_q <= 1'b0; active_q <= 1'b0; busy_q <= 1'b0;
      err_q <= 1'b0; err_ch_q <= '0; err_dir_q <= 1'b0;
    end else if (swrst_i) begin
      state_q <= S_IDLE; req_q <= '0; en_q <= '0; idx_q <= '0; cnt_q <= '0;
      done_q <= 1'b0; stopped_q <= 1'b0; active_q <= 1'b0; busy_q <= 1'b0;
      err_q <= 1'b0; err_ch_q <= '0; err_dir_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      stopped_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= S_UP;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= ch_en_i;
            req_q   <= NUM_CH'(ch_en_i[0]);
            busy_q  <= 1'b1;
          end
        end
        S_UP: begin
          if (stop_i) begin
            // Abort releases the current stage even if its ack never arrived.
            state_q      <= S_DOWN;
            req_q[idx_q] <= 1'b0;
            cnt_q        <= '0;
          end else if (!cur_en_d || cur_ack_d) begin
            if (idx_q == IDX_LAST) begin
              state_q  <= S_ACTIVE;
              active_q <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              idx_q            <= idx_inc_d;
              req_q[idx_inc_d] <= en_q[idx_inc_d];
              cnt_q            <= '0;
            end
          end else if (to_hit_d) begin
            state_q   <= S_ERR;
            req_q     <= '0;
            err_q     <= 1'b1;
            err_ch_q  <= idx_q;
            err_dir_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ACTIVE: begin
          if (|drop_d) begin
            state_q   <= S_ERR;
            req_q     <= '0;
            active_q  <= 1'b0;
            err_q     <= 1'b1;
            err_ch_q  <= drop_idx_d;
            err_dir_q <= 1'b1;
          end else if (stop_i) begin
            state_q         <= S_DOWN;
            idx_q           <= IDX_LAST;
            req_q[IDX_LAST] <= 1'b0;
            cnt_q           <= '0;
            active_q        <= 1'b0;
          end
        end
        S_DOWN: begin
          if (!cur_en_d || !cur_ack_d) begin
            if (idx_q == '0) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              stopped_q <= 1'b1;
            end else begin
              idx_q            <= idx_dec_d;
              req_q[idx_dec_d] <= 1'b0;
              cnt_q            <= '0;
            end
          end else if (to_hit_d) begin
            state_q   <= S_ERR;
            req_q     <= '0;
            err_q     <= 1'b1;
            err_ch_q  <= idx_q;
            err_dir_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ERR: begin
          if (stop_i) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            err_ch_q  <= '0;
            err_dir_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_o     = req_q;
  assign done_o    = done_q;
  assign stopped_o = stopped_q;
  assign active_o  = active_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign err_ch_o  = err_ch_q;
  assign err_dir_o = err_dir_q;

endmodule
